// File: rtl/scpad_pkg.sv
// Shared scratchpad types: request payloads, requester source tags and bus widths.
package scpad_pkg;

  localparam int SCPAD_ID_WIDTH = 2;
  localparam int ADDR_W         = 16;
  localparam int DATA_W         = 32;

  typedef enum logic {
    SRC_FE = 1'b0,
    SRC_BE = 1'b1
  } src_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef struct packed {
    req_t req;
    src_e src;
  } bank_req_t;

endpackage

// File: rtl/scpad_req_arbiter_slot.sv
// Enable-loaded holding register used as the single bank request output slot.
module scpad_req_arbiter_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/scpad_req_arbiter.sv
// FE/BE request arbiter for one scratchpad bank: FE priority with BE anti-starvation,
// in-flight credit tracking and a flush/drain handshake.
module scpad_req_arbiter
  import scpad_pkg::*;
#(
  parameter logic [SCPAD_ID_WIDTH-1:0] IDX             = '0,
  parameter int                        MAX_OUTSTANDING = 4,
  parameter int                        STARVE_LIMIT    = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 fe_req_valid,
  input  req_t                                 fe_req,
  output logic                                 fe_req_ready,
  input  logic                                 be_req_valid,
  input  req_t                                 be_req,
  output logic                                 be_req_ready,
  output logic                                 bank_req_valid,
  output bank_req_t                            bank_req,
  input  logic                                 bank_req_ready,
  input  logic                                 bank_done,
  input  logic                                 flush,
  output logic                                 flush_done,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 err_underflow
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  // An IDX wider than the bank id field can never address a real bank.
  if (IDX >= SCPAD_ID_WIDTH'((1 << SCPAD_ID_WIDTH) - 1) + 1) begin : g_idx_range
    $error("scpad_req_arbiter: IDX out of range");
  end

  logic [0:0]       state_q, state_d;
  logic [STV_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic             err_underflow_q, err_underflow_d;
  logic             bank_req_valid_q, bank_req_valid_d;

  logic             slot_free, grant_ok, be_wins;
  logic             fe_grant, be_grant, grant;
  logic             done_ok, drain_empty;
  bank_req_t        slot_d;
  logic [$bits(bank_req_t)-1:0] slot_q;

  always_comb begin
    slot_free = !bank_req_valid_q || bank_req_ready;
    grant_ok  = (state_q == ST_RUN) && slot_free &&
                (outstanding_q < OUT_W'(MAX_OUTSTANDING));
    be_wins   = be_req_valid &&
                (!fe_req_valid || (starve_cnt_q == STV_W'(STARVE_LIMIT)));
    fe_grant  = grant_ok && fe_req_valid && !be_wins;
    be_grant  = grant_ok && be_wins;
    grant     = fe_grant || be_grant;
  end

  always_comb begin
    slot_d.req = fe_req;
    slot_d.src = SRC_FE;
    if (be_grant) begin
      slot_d.req = be_req;
      slot_d.src = SRC_BE;
    end
  end

  scpad_req_arbiter_slot #(
    .W ($bits(bank_req_t))
  ) u_slot (
    .clk (clk),
    .rst (rst),
    .en  (grant),
    .d   (slot_d),
    .q   (slot_q)
  );

  always_comb begin
    bank_req_valid_d = bank_req_valid_q;
    if (grant)               bank_req_valid_d = 1'b1;
    else if (bank_req_ready) bank_req_valid_d = 1'b0;
  end

  // BE loss counter saturates so a long FE burst cannot wrap it back to zero.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (be_grant || !be_req_valid)
      starve_cnt_d = '0;
    else if (starve_cnt_q != STV_W'(STARVE_LIMIT))
      starve_cnt_d = starve_cnt_q + 1'b1;
  end

  // A completion with nothing in flight is flagged rather than wrapping the counter.
  always_comb begin
    done_ok         = bank_done && (outstanding_q != '0);
    err_underflow_d = err_underflow_q || (bank_done && (outstanding_q == '0));
    outstanding_d   = outstanding_q;
    case ({grant, done_ok})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_comb begin
    drain_empty = !bank_req_valid_q && (outstanding_q == '0);
    flush_done  = 1'b0;
    state_d     = state_q;
    case (state_q)
      ST_RUN: begin
        if (flush) state_d = ST_DRAIN;
      end
      default: begin
        if (drain_empty) begin
          state_d    = ST_RUN;
          flush_done = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_RUN;
      starve_cnt_q     <= '0;
      outstanding_q    <= '0;
      err_underflow_q  <= 1'b0;
      bank_req_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      starve_cnt_q     <= starve_cnt_d;
      outstanding_q    <= outstanding_d;
      err_underflow_q  <= err_underflow_d;
      bank_req_valid_q <= bank_req_valid_d;
    end
  end

  assign fe_req_ready   = fe_grant;
  assign be_req_ready   = be_grant;
  assign bank_req_valid = bank_req_valid_q;
  assign bank_req       = slot_q;
  assign outstanding    = outstanding_q;
  assign err_underflow  = err_underflow_q;

endmodule

// File: tb/tb_scpad_req_arbiter.sv
// Directed bench for scpad_req_arbiter with a reference model and a bank_req scoreboard.
module tb_scpad_req_arbiter;
  import scpad_pkg::*;

  localparam int MAX_OUT = 4;
  localparam int SL      = 8;
  localparam int OW      = $clog2(MAX_OUT + 1);

  logic      clk = 1'b0;
  logic      rst;
  logic      fe_req_valid, be_req_valid, bank_req_ready, bank_done, flush;
  req_t      fe_req, be_req;
  logic      fe_req_ready, be_req_ready, bank_req_valid, flush_done, err_underflow;
  bank_req_t bank_req;
  logic [OW-1:0] outstanding;

  int n_cmp = 0;
  int n_err = 0;
  bank_req_t sb_q[$];

  int m_out, m_starve;
  bit m_slot_v, m_drain, m_err, chk_en;
  bit o_fe, o_be, o_fd;
  bit g_d1, g_d2;
  int cnt;

  scpad_req_arbiter #(
    .IDX             ('0),
    .MAX_OUTSTANDING (MAX_OUT),
    .STARVE_LIMIT    (SL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fe_req_valid   (fe_req_valid),
    .fe_req         (fe_req),
    .fe_req_ready   (fe_req_ready),
    .be_req_valid   (be_req_valid),
    .be_req         (be_req),
    .be_req_ready   (be_req_ready),
    .bank_req_valid (bank_req_valid),
    .bank_req       (bank_req),
    .bank_req_ready (bank_req_ready),
    .bank_done      (bank_done),
    .flush          (flush),
    .flush_done     (flush_done),
    .outstanding    (outstanding),
    .err_underflow  (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit fv, input bit bv, input bit brr, input bit done, input bit fl);
    fe_req_valid   = fv;
    be_req_valid   = bv;
    bank_req_ready = brr;
    bank_done      = done;
    flush          = fl;
    fe_req.write   = 1'($urandom_range(0, 1));
    fe_req.addr    = 16'($urandom);
    fe_req.wdata   = $urandom;
    be_req.write   = 1'($urandom_range(0, 1));
    be_req.addr    = 16'($urandom);
    be_req.wdata   = $urandom;
  endtask

  // Compare mid-cycle against the model, then advance model and clock.
  task automatic tick();
    bit free, ok, bew, e_fe, e_be, fd_exp, g;
    bank_req_t e;
    @(negedge clk);
    free   = !m_slot_v || bank_req_ready;
    ok     = !m_drain && free && (m_out < MAX_OUT);
    bew    = be_req_valid && (!fe_req_valid || m_starve == SL);
    e_fe   = ok && fe_req_valid && !bew;
    e_be   = ok && bew;
    g      = e_fe || e_be;
    fd_exp = m_drain && !m_slot_v && (m_out == 0);
    o_fe = fe_req_ready; o_be = be_req_ready; o_fd = flush_done;
    if (chk_en) begin
      chk("fe_req_ready", fe_req_ready, e_fe);
      chk("be_req_ready", be_req_ready, e_be);
      chk("bank_req_valid", bank_req_valid, m_slot_v);
      chk("outstanding", outstanding, m_out);
      chk("err_underflow", err_underflow, m_err);
      chk("flush_done", flush_done, fd_exp);
      if (m_slot_v) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_err++;
          $error("FAIL bank_req: observed %0h, expected none queued", bank_req);
        end else begin
          chk("bank_req", bank_req, sb_q[0]);
        end
      end
    end
    if (m_slot_v && bank_req_ready && sb_q.size() > 0) void'(sb_q.pop_front());
    if (e_fe) begin e.req = fe_req; e.src = SRC_FE; sb_q.push_back(e); end
    if (e_be) begin e.req = be_req; e.src = SRC_BE; sb_q.push_back(e); end
    if (rst) begin
      m_out = 0; m_starve = 0; m_slot_v = 0; m_drain = 0; m_err = 0;
      sb_q.delete();
    end else begin
      if (g) m_slot_v = 1;
      else if (bank_req_ready) m_slot_v = 0;
      if (e_be || !be_req_valid) m_starve = 0;
      else if (m_starve < SL) m_starve++;
      if (bank_done && m_out == 0) begin
        m_err = 1;
        m_out = m_out + int'(g);
      end else begin
        m_out = m_out + int'(g) - int'(bank_done);
      end
      if (m_drain) begin
        if (fd_exp) m_drain = 0;
      end else if (flush) begin
        m_drain = 1;
      end
    end
    g_d2 = g_d1;
    g_d1 = g;
    @(posedge clk);
    #1;
  endtask

  initial begin
    chk_en = 0;
    m_out = 0; m_starve = 0; m_slot_v = 0; m_drain = 0; m_err = 0;
    g_d1 = 0; g_d2 = 0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_bank_req_valid", bank_req_valid, 0);
    chk("rst_bank_req", bank_req, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err_underflow", err_underflow, 0);
    chk("rst_flush_done", flush_done, 0);
    chk_en = 1;

    // Completion with nothing in flight.
    drive(0, 0, 1, 1, 0); tick();
    chk("underflow_err", err_underflow, 1);
    chk("underflow_out", outstanding, 0);

    // Both requesters always valid: 8 FE grants then 1 BE grant.
    g_d1 = 0; g_d2 = 0;
    for (int i = 0; i < 18; i++) begin
      drive(1, 1, 1, g_d2, 0); tick();
      chk($sformatf("rr_fe_%0d", i), o_fe, (i % 9) != 8);
      chk($sformatf("rr_be_%0d", i), o_be, (i % 9) == 8);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, g_d2, 0); tick();
    end
    chk("rr_drained", outstanding, 0);

    // Credit limit with no completions.
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 1, 0, 0); tick();
      cnt += int'(o_fe);
    end
    chk("credit_grants", cnt, 4);
    chk("credit_out", outstanding, 4);
    chk("credit_blocked", o_fe, 0);
    drive(1, 0, 1, 1, 0); tick();
    chk("credit_done_cycle", o_fe, 0);
    drive(1, 0, 1, 0, 0); tick();
    chk("credit_regrant", o_fe, 1);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 1, 0); tick();
    end
    chk("credit_drained", outstanding, 0);

    // Backpressure: slot held three cycles, then transfer plus new grant.
    drive(1, 0, 1, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0); tick();
      chk($sformatf("bp_nogrant_%0d", i), o_fe, 0);
    end
    drive(1, 0, 1, 0, 0); tick();
    chk("bp_release_grant", o_fe, 1);
    chk("bp_out", outstanding, 2);
    drive(0, 0, 1, 1, 0); tick();
    drive(0, 0, 1, 1, 0); tick();

    // Flush coinciding with a grant, then drain of three completions.
    drive(1, 0, 1, 0, 0); tick();
    drive(1, 0, 1, 0, 0); tick();
    drive(1, 0, 1, 0, 1); tick();
    chk("flush_same_cycle_grant", o_fe, 1);
    chk("flush_out3", outstanding, 3);
    drive(1, 0, 1, 1, 0); tick();
    chk("drain_nogrant_1", o_fe, 0);
    drive(1, 0, 1, 1, 1); tick();
    chk("drain_nogrant_2", o_fe, 0);
    drive(1, 0, 1, 1, 0); tick();
    chk("drain_nogrant_3", o_fe, 0);
    chk("drain_out0", outstanding, 0);
    drive(1, 0, 1, 0, 0); tick();
    chk("flush_done_pulse", o_fd, 1);
    chk("flush_done_nogrant", o_fe, 0);
    drive(1, 0, 1, 0, 0); tick();
    chk("flush_done_single", o_fd, 0);
    chk("resume_grant", o_fe, 1);
    drive(0, 0, 1, 1, 0); tick();

    // Grant and completion in the same cycle.
    drive(1, 0, 1, 0, 0); tick();
    drive(1, 0, 1, 0, 0); tick();
    drive(1, 0, 1, 1, 0); tick();
    chk("simul_grant", o_fe, 1);
    chk("simul_out", outstanding, 2);
    drive(0, 0, 1, 1, 0); tick();
    drive(0, 0, 1, 1, 0); tick();

    // Reset mid-operation with slot full and three in flight.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 0, 0); tick();
    end
    chk("pre_rst_out", outstanding, 3);
    chk("pre_rst_valid", bank_req_valid, 1);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0); tick();
    rst = 1'b0;
    chk("mid_rst_valid", bank_req_valid, 0);
    chk("mid_rst_bank_req", bank_req, 0);
    chk("mid_rst_out", outstanding, 0);
    chk("mid_rst_err", err_underflow, 0);
    chk("mid_rst_flush_done", flush_done, 0);
    drive(0, 0, 1, 1, 0); tick();
    chk("post_rst_underflow", err_underflow, 1);
    chk("post_rst_out", outstanding, 0);

    drive(0, 0, 1, 0, 0); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
